// File: rtl/curve_correct_pipe_if.sv
// rtl/curve_correct_pipe_if.sv - pixel stream, coefficient write port and corrected output of curve_correct_pipe.
// clip_cnt exists only when CC_CLIP_COUNT_EN is defined.
interface curve_correct_pipe_if #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 20
);
  logic                  pix_dval;
  logic                  pix_fval;
  logic [DATA_WIDTH-1:0] pix_red;
  logic [DATA_WIDTH-1:0] pix_green;
  logic [DATA_WIDTH-1:0] pix_blue;
  logic                  wr_en;
  logic [2:0]            wr_addr;
  logic [15:0]           wr_data;
  logic                  cor_dval;
  logic [DATA_WIDTH-1:0] cor_red;
  logic [DATA_WIDTH-1:0] cor_green;
  logic [DATA_WIDTH-1:0] cor_blue;
`ifdef CC_CLIP_COUNT_EN
  logic [CNT_WIDTH-1:0]  clip_cnt;
`endif

  modport master (
    output pix_dval, pix_fval, pix_red, pix_green, pix_blue,
    output wr_en, wr_addr, wr_data,
`ifdef CC_CLIP_COUNT_EN
    input  clip_cnt,
`endif
    input  cor_dval, cor_red, cor_green, cor_blue
  );

  modport slave (
    input  pix_dval, pix_fval, pix_red, pix_green, pix_blue,
    input  wr_en, wr_addr, wr_data,
`ifdef CC_CLIP_COUNT_EN
    output clip_cnt,
`endif
    output cor_dval, cor_red, cor_green, cor_blue
  );
endinterface

// File: rtl/curve_correct_pipe.sv
// rtl/curve_correct_pipe.sv - 3-stage per-channel RGB offset/gain correction with blanking-only coefficient update.
// Optional saturated-pixel counter enabled by CC_CLIP_COUNT_EN.
module curve_correct_pipe #(
  parameter int DATA_WIDTH = 10,
  parameter int GAIN_WIDTH = 12,
  parameter int GAIN_FRAC  = 9,
  parameter int CNT_WIDTH  = 20
) (
  input logic               clk,
  input logic               rst,
  curve_correct_pipe_if.slave bus
);
  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 2;
  localparam logic signed [PW-1:0] MAX_V = PW'((1 << DATA_WIDTH) - 1);

  logic [GAIN_WIDTH-1:0] sh_gain [3];
  logic [GAIN_WIDTH-1:0] ac_gain [3];
  logic [DATA_WIDTH-1:0] sh_off  [3];
  logic [DATA_WIDTH-1:0] ac_off  [3];
  logic                  sh_byp, ac_byp;

  logic [DATA_WIDTH-1:0] pix [3];
  assign pix[0] = bus.pix_red;
  assign pix[1] = bus.pix_green;
  assign pix[2] = bus.pix_blue;

  // Active takes the pre-write shadow value, so a write coinciding with a transfer lands one blanking cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_gain <= '{GAIN_WIDTH'(500), GAIN_WIDTH'(420), GAIN_WIDTH'(500)};
      ac_gain <= '{GAIN_WIDTH'(500), GAIN_WIDTH'(420), GAIN_WIDTH'(500)};
      sh_off  <= '{DATA_WIDTH'(10), DATA_WIDTH'(30), DATA_WIDTH'(10)};
      ac_off  <= '{DATA_WIDTH'(10), DATA_WIDTH'(30), DATA_WIDTH'(10)};
      sh_byp  <= 1'b0;
      ac_byp  <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        case (bus.wr_addr)
          3'd0: sh_gain[0] <= bus.wr_data[GAIN_WIDTH-1:0];
          3'd1: sh_off[0]  <= bus.wr_data[DATA_WIDTH-1:0];
          3'd2: sh_gain[1] <= bus.wr_data[GAIN_WIDTH-1:0];
          3'd3: sh_off[1]  <= bus.wr_data[DATA_WIDTH-1:0];
          3'd4: sh_gain[2] <= bus.wr_data[GAIN_WIDTH-1:0];
          3'd5: sh_off[2]  <= bus.wr_data[DATA_WIDTH-1:0];
          3'd6: sh_byp     <= bus.wr_data[0];
          default: ;
        endcase
      end
      if (!bus.pix_fval) begin
        ac_gain <= sh_gain;
        ac_off  <= sh_off;
        ac_byp  <= sh_byp;
      end
    end
  end

  logic signed [DATA_WIDTH:0]   s1_diff [3];
  logic [GAIN_WIDTH-1:0]        s1_gain [3];
  logic [DATA_WIDTH-1:0]        s1_raw  [3];
  logic [DATA_WIDTH-1:0]        s2_raw  [3];
  logic signed [PW-1:0]         s2_prod [3];
  logic [DATA_WIDTH-1:0]        out     [3];
  logic                         s1_v, s2_v, out_v, s1_byp, s2_byp;
  logic signed [PW-1:0]         shifted [3];
  logic [2:0]                   sat_lo, sat_hi;
  logic [DATA_WIDTH-1:0]        clamped [3];

  always_comb begin
    sat_lo = '0;
    sat_hi = '0;
    for (int c = 0; c < 3; c++) begin
      shifted[c] = s2_prod[c] >>> GAIN_FRAC;
      clamped[c] = shifted[c][DATA_WIDTH-1:0];
      if (shifted[c] < 0) begin
        sat_lo[c]  = 1'b1;
        clamped[c] = '0;
      end else if (shifted[c] > MAX_V) begin
        sat_hi[c]  = 1'b1;
        clamped[c] = '1;
      end
    end
  end

  // Coefficients travel with the pixel so every stage uses the set sampled at input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_diff <= '{default: '0};
      s1_gain <= '{default: '0};
      s1_raw  <= '{default: '0};
      s2_raw  <= '{default: '0};
      s2_prod <= '{default: '0};
      out     <= '{default: '0};
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      out_v   <= 1'b0;
      s1_byp  <= 1'b0;
      s2_byp  <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        s1_diff[c] <= $signed({1'b0, pix[c]}) - $signed({1'b0, ac_off[c]});
        s1_gain[c] <= ac_gain[c];
        s1_raw[c]  <= pix[c];
        s2_prod[c] <= PW'(s1_diff[c]) * PW'($signed({1'b0, s1_gain[c]}));
        s2_raw[c]  <= s1_raw[c];
        out[c]     <= s2_byp ? s2_raw[c] : clamped[c];
      end
      s1_v   <= bus.pix_dval;
      s2_v   <= s1_v;
      out_v  <= s2_v;
      s1_byp <= ac_byp;
      s2_byp <= s1_byp;
    end
  end

  assign bus.cor_dval  = out_v;
  assign bus.cor_red   = out[0];
  assign bus.cor_green = out[1];
  assign bus.cor_blue  = out[2];

`ifdef CC_CLIP_COUNT_EN
  logic                 fval_d;
  logic                 hit;
  logic [CNT_WIDTH-1:0] cnt, clip_q;

  assign hit = s2_v && !s2_byp && ((|sat_lo) || (|sat_hi));

  // A clipped pixel on the falling-edge cycle opens the new frame's count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fval_d <= 1'b0;
      cnt    <= '0;
      clip_q <= '0;
    end else begin
      fval_d <= bus.pix_fval;
      if (fval_d && !bus.pix_fval) begin
        clip_q <= cnt;
        cnt    <= CNT_WIDTH'(hit);
      end else if (hit && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.clip_cnt = clip_q;
`endif
endmodule

// File: tb/tb_curve_correct_pipe.sv
// tb/tb_curve_correct_pipe.sv - directed bench with a cycle-level reference model for curve_correct_pipe.
module tb_curve_correct_pipe;
  localparam int DW = 10, GW = 12, GF = 9, CW = 20;
  localparam int MAXV = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  curve_correct_pipe_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

  curve_correct_pipe #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW), .GAIN_FRAC(GF), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  typedef struct {bit v; int r; int g; int b; bit clip;} ent_t;
  ent_t p0, p1, mo;
  int sh_g[3], sh_o[3], ac_g[3], ac_o[3];
  bit sh_b, ac_b;
  int m_cnt, m_clip;
  bit m_fd;

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int corr(int x, int g, int o, bit byp, inout bit clip);
    longint p;
    if (byp) return x;
    p = longint'(x - o) * longint'(g);
    p = p >>> GF;
    if (p < 0) begin clip = 1'b1; return 0; end
    if (p > MAXV) begin clip = 1'b1; return MAXV; end
    return int'(p);
  endfunction

  always @(posedge clk) begin : model
    ent_t n;
    int a, d;
    int og[3], oo[3];
    bit ob, hit;
    if (rst) begin
      p0 = '{default: 0}; p1 = '{default: 0}; mo = '{default: 0};
      sh_g = '{500, 420, 500}; sh_o = '{10, 30, 10}; sh_b = 1'b0;
      ac_g = sh_g; ac_o = sh_o; ac_b = 1'b0;
      m_cnt = 0; m_clip = 0; m_fd = 1'b0;
    end else begin
      hit = p1.v && p1.clip;
      if (m_fd && !bus.pix_fval) begin
        m_clip = m_cnt;
        m_cnt = hit ? 1 : 0;
      end else if (hit && m_cnt != (1 << CW) - 1) begin
        m_cnt++;
      end
      m_fd = bus.pix_fval;
      mo = p1;
      p1 = p0;
      n.v = bus.pix_dval;
      n.clip = 1'b0;
      n.r = corr(int'(bus.pix_red),   ac_g[0], ac_o[0], ac_b, n.clip);
      n.g = corr(int'(bus.pix_green), ac_g[1], ac_o[1], ac_b, n.clip);
      n.b = corr(int'(bus.pix_blue),  ac_g[2], ac_o[2], ac_b, n.clip);
      p0 = n;
      og = sh_g; oo = sh_o; ob = sh_b;
      if (bus.wr_en) begin
        a = int'(bus.wr_addr);
        d = int'(bus.wr_data);
        case (a)
          0, 2, 4: sh_g[a / 2] = d % (1 << GW);
          1, 3, 5: sh_o[a / 2] = d % (1 << DW);
          6:       sh_b = d[0];
          default: ;
        endcase
      end
      if (!bus.pix_fval) begin
        ac_g = og; ac_o = oo; ac_b = ob;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_dval", int'(bus.cor_dval), int'(mo.v));
      if (mo.v) begin
        chk("m_red",   int'(bus.cor_red),   mo.r);
        chk("m_green", int'(bus.cor_green), mo.g);
        chk("m_blue",  int'(bus.cor_blue),  mo.b);
      end
`ifdef CC_CLIP_COUNT_EN
      chk("m_clip_cnt", int'(bus.clip_cnt), m_clip);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(bit v, int r, int g, int b);
    bus.pix_dval  = v;
    bus.pix_red   = DW'(r);
    bus.pix_green = DW'(g);
    bus.pix_blue  = DW'(b);
    cyc();
  endtask

  task automatic wr(int a, int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_data = 16'(d);
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    bus.pix_dval = 1'b0; bus.pix_fval = 1'b0;
    bus.pix_red = '0; bus.pix_green = '0; bus.pix_blue = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_dval", int'(bus.cor_dval), 0);
    chk("rst_red",  int'(bus.cor_red), 0);
    chk("rst_blue", int'(bus.cor_blue), 0);

    bus.pix_fval = 1'b1;
    pix(1, 100, 100, 100); pix(0, 0, 0, 0); pix(0, 0, 0, 0);
    chk("def_dval",  int'(bus.cor_dval), 1);
    chk("def_red",   int'(bus.cor_red), 87);
    chk("def_green", int'(bus.cor_green), 57);
    chk("def_blue",  int'(bus.cor_blue), 87);
    pix(1, 5, 20, 1023); pix(0, 0, 0, 0); pix(0, 0, 0, 0);
    chk("low_red",   int'(bus.cor_red), 0);
    chk("low_green", int'(bus.cor_green), 0);
    chk("hi_blue",   int'(bus.cor_blue), 989);

    bus.pix_fval = 1'b0;
    wr(0, 2048);
    wr(1, 16'hFC0A);
    cyc();
    bus.pix_fval = 1'b1;
    pix(1, 1000, 100, 100); pix(1, 1000, 100, 100); pix(1, 1000, 100, 100);
    pix(0, 0, 0, 0); pix(0, 0, 0, 0);
    chk("sat_red", int'(bus.cor_red), 1023);
    pix(0, 0, 0, 0);
    bus.pix_fval = 1'b0;
    cyc();
`ifdef CC_CLIP_COUNT_EN
    chk("clip_cnt3", int'(bus.clip_cnt), 3);
`endif

    bus.pix_fval = 1'b1;
    wr(2, 512); wr(3, 0);
    pix(1, 100, 100, 100); pix(0, 0, 0, 0); pix(0, 0, 0, 0);
    chk("frame_green", int'(bus.cor_green), 57);
    chk("frame_red",   int'(bus.cor_red), 360);
    bus.pix_fval = 1'b0;
    pix(0, 0, 0, 0);
    bus.pix_fval = 1'b1;
    pix(1, 100, 100, 100); pix(0, 0, 0, 0); pix(0, 0, 0, 0);
    chk("unity_green", int'(bus.cor_green), 100);

    bus.pix_fval = 1'b0;
    wr(6, 1); wr(7, 16'hFFFF);
    cyc();
    bus.pix_fval = 1'b1;
    pix(1, 7, 500, 1023); pix(0, 1, 2, 3); pix(1, 8, 9, 10);
    chk("byp_dval0",  int'(bus.cor_dval), 1);
    chk("byp_red",    int'(bus.cor_red), 7);
    chk("byp_green",  int'(bus.cor_green), 500);
    chk("byp_blue",   int'(bus.cor_blue), 1023);
    pix(0, 0, 0, 0);
    chk("byp_dval1",  int'(bus.cor_dval), 0);
    pix(0, 0, 0, 0);
    chk("byp_dval2",  int'(bus.cor_dval), 1);
    chk("byp_red2",   int'(bus.cor_red), 8);

    pix(1, 200, 200, 200); pix(1, 300, 300, 300); pix(1, 400, 400, 400);
    rst = 1'b1;
    pix(1, 500, 500, 500);
    rst = 1'b0;
    chk("mid_rst_dval", int'(bus.cor_dval), 0);
    chk("mid_rst_red",  int'(bus.cor_red), 0);
    pix(1, 100, 100, 100); pix(0, 0, 0, 0); pix(0, 0, 0, 0);
    chk("post_rst_red",   int'(bus.cor_red), 87);
    chk("post_rst_green", int'(bus.cor_green), 57);
    pix(0, 0, 0, 0); pix(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
